// File: rtl/sum_checker_pkg.sv
// Shared types and constants for the sum_checker adder self-test block.
package sum_checker_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [7:0] NO_FAIL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // Fibonacci step: shift left, feedback from bits 15, 13, 12 and 10.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload; q is the register itself.
module lfsr16
    import sum_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sum_checker.sv
// Adder BIST: drives LFSR operand pairs, samples the returned sum LAT cycles later, tallies errors.
// Define SUM_CHECKER_STOP_ON_FAIL_EN to end the run at the first mismatch.
module sum_checker
    import sum_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LAT         = 1,
    parameter int unsigned NUM_VECTORS = 255,
    parameter logic [15:0] SEED        = 16'hA55A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sum_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       first_fail
);

    localparam int unsigned CNT_W = 4;
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LAT - 1);

    state_e state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       ff_q, ff_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_q;
    logic              mismatch;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (SEED_EFF),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign mismatch = (sum_in != exp_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ff_d      = ff_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        exp_d     = exp_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    err_d     = 8'd0;
                    idx_d     = 8'd0;
                    ff_d      = NO_FAIL;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                op_a_d    = lfsr_q[15 -: WIDTH];
                op_b_d    = lfsr_q[7 -: WIDTH];
                exp_d     = op_a_d + op_b_d;
                lfsr_step = 1'b1;
                cnt_d     = WAIT_INIT;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = DRIVE;
                end
                if (mismatch) begin
`ifdef SUM_CHECKER_STOP_ON_FAIL_EN
                    err_d   = 8'd1;
                    ff_d    = idx_q;
                    state_d = DONE;
`else
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (ff_q == NO_FAIL) begin
                        ff_d = idx_q;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they align with it.
        busy_d = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            cnt_q   <= '0;
            err_q   <= 8'd0;
            ff_q    <= NO_FAIL;
            op_a_q  <= '0;
            op_b_q  <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
